// File: rtl/ram_rd_resp_if.sv
// Signal bundle for ram_rd_resp: read requests, write requests, SRAM macro port and row return.
// The slave modport is the ram_rd_resp side; master is the surrounding environment.
interface ram_rd_resp_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 128
);
  logic                      ram_read_vld;
  logic [ADDR_WIDTH-1:0]     ram_read_addr;
  logic                      ram_read_rdy;
  logic                      wr_vld;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [DATA_WIDTH/8-1:0]   wr_strb;
  logic                      wr_rdy;
  logic                      sram_ce;
  logic                      sram_we;
  logic [ADDR_WIDTH-1:0]     sram_addr;
  logic [DATA_WIDTH-1:0]     sram_wdata;
  logic [DATA_WIDTH/8-1:0]   sram_wbe;
  logic [DATA_WIDTH-1:0]     sram_rdata;
  logic                      ram_buff_alloc_vld;
  logic [ADDR_WIDTH-1:0]     ram_buff_alloc_addr;
  logic [DATA_WIDTH-1:0]     ram_buff_alloc_data;

  modport slave (
    input  ram_read_vld, ram_read_addr, wr_vld, wr_addr, wr_data, wr_strb, sram_rdata,
    output ram_read_rdy, wr_rdy, sram_ce, sram_we, sram_addr, sram_wdata, sram_wbe,
           ram_buff_alloc_vld, ram_buff_alloc_addr, ram_buff_alloc_data
  );

  modport master (
    output ram_read_vld, ram_read_addr, wr_vld, wr_addr, wr_data, wr_strb, sram_rdata,
    input  ram_read_rdy, wr_rdy, sram_ce, sram_we, sram_addr, sram_wdata, sram_wbe,
           ram_buff_alloc_vld, ram_buff_alloc_addr, ram_buff_alloc_data
  );
endinterface

// File: rtl/ram_rd_resp.sv
// Single-port SRAM arbiter: queues row-read requests, shares the port with writes under a
// starvation limit, and returns each read row two cycles after issue as a one-cycle pulse.
module ram_rd_resp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_rd_resp_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  logic [ADDR_WIDTH-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [STV_W-1:0]      starve_cnt_r;
  logic                  init_done_r;
  logic                  s1_vld_r;
  logic [ADDR_WIDTH-1:0] s1_addr_r;
  logic                  alloc_vld_r;
  logic [ADDR_WIDTH-1:0] alloc_addr_r;
  logic [DATA_WIDTH-1:0] alloc_data_r;

  logic                  rd_pend_s;
  logic                  force_rd_s;
  logic                  rd_rdy_s;
  logic                  wr_rdy_s;
  logic                  wr_gnt_s;
  logic                  rd_gnt_s;
  logic                  push_s;
  logic                  pop_s;
  logic [ADDR_WIDTH-1:0] head_s;
  logic                  sram_ce_s;
  logic                  sram_we_s;
  logic [ADDR_WIDTH-1:0] sram_addr_s;
  logic [DATA_WIDTH-1:0] sram_wdata_s;
  logic [BE_W-1:0]       sram_wbe_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  // Writes win the port unless a queued read has waited through STARVE_MAX write grants.
  assign rd_pend_s  = (count_r != {CNT_W{1'b0}});
  assign force_rd_s = rd_pend_s & (starve_cnt_r == STV_MAX);
  assign rd_rdy_s   = init_done_r & (count_r < CNT_FULL);
  assign wr_rdy_s   = init_done_r & ~force_rd_s;
  assign wr_gnt_s   = bus.wr_vld & wr_rdy_s;
  assign rd_gnt_s   = ~wr_gnt_s & init_done_r & rd_pend_s;
  assign push_s     = bus.ram_read_vld & rd_rdy_s;
  assign pop_s      = rd_gnt_s;
  assign head_s     = fifo_mem_r[rd_ptr_r];

  // SRAM port mux: write grant, else read grant from the queue head, else idle.
  always_comb begin
    sram_ce_s    = 1'b0;
    sram_we_s    = 1'b0;
    sram_addr_s  = {ADDR_WIDTH{1'b0}};
    sram_wdata_s = {DATA_WIDTH{1'b0}};
    sram_wbe_s   = {BE_W{1'b0}};
    if (wr_gnt_s) begin
      sram_ce_s    = 1'b1;
      sram_we_s    = 1'b1;
      sram_addr_s  = bus.wr_addr;
      sram_wdata_s = bus.wr_data;
      sram_wbe_s   = bus.wr_strb;
    end else if (rd_gnt_s) begin
      sram_ce_s    = 1'b1;
      sram_addr_s  = head_s;
    end else begin
      sram_ce_s    = 1'b0;
    end
  end

  // Request queue storage; entries beyond the pointers are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.ram_read_addr;
    end
  end

  // Queue pointers, occupancy and the post-reset enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      init_done_r <= 1'b1;
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Counts write grants taken while a read is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {STV_W{1'b0}};
    end else if (rd_gnt_s || !rd_pend_s) begin
      starve_cnt_r <= {STV_W{1'b0}};
    end else if (wr_gnt_s && (starve_cnt_r != STV_MAX)) begin
      starve_cnt_r <= starve_cnt_r + STV_W'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Two-stage return pipe matching the one-cycle SRAM read latency; outputs hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_r     <= 1'b0;
      s1_addr_r    <= {ADDR_WIDTH{1'b0}};
      alloc_vld_r  <= 1'b0;
      alloc_addr_r <= {ADDR_WIDTH{1'b0}};
      alloc_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      s1_vld_r    <= rd_gnt_s;
      alloc_vld_r <= s1_vld_r;
      if (rd_gnt_s) begin
        s1_addr_r <= head_s;
      end
      if (s1_vld_r) begin
        alloc_addr_r <= s1_addr_r;
        alloc_data_r <= bus.sram_rdata;
      end
    end
  end

  assign bus.ram_read_rdy        = rd_rdy_s;
  assign bus.wr_rdy              = wr_rdy_s;
  assign bus.sram_ce             = sram_ce_s;
  assign bus.sram_we             = sram_we_s;
  assign bus.sram_addr           = sram_addr_s;
  assign bus.sram_wdata          = sram_wdata_s;
  assign bus.sram_wbe            = sram_wbe_s;
  assign bus.ram_buff_alloc_vld  = alloc_vld_r;
  assign bus.ram_buff_alloc_addr = alloc_addr_r;
  assign bus.ram_buff_alloc_data = alloc_data_r;
endmodule

// File: tb/tb_ram_rd_resp.sv
// Directed bench for ram_rd_resp: stimulus pushes expected rows on acceptance, a monitor checks
// every alloc pulse; unwritten SRAM rows read back as their address byte replicated.
module tb_ram_rd_resp;
  localparam int AW = 8;
  localparam int DW = 128;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_rd_resp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  ram_rd_resp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .STARVE_MAX(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int            n_chk   = 0;
  int            n_pass  = 0;
  int            n_alloc = 0;
  int            saved_alloc;
  exp_t          sb[$];
  logic [DW-1:0] rd_exp;
  logic [DW-1:0] mem [256];
  bit            written [256];

  // SRAM macro model with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.sram_ce === 1'b1) begin
      if (bus.sram_we === 1'b1) begin
        if (!written[bus.sram_addr]) mem[bus.sram_addr] <= {BW{bus.sram_addr}};
        for (int b = 0; b < BW; b++) begin
          if (bus.sram_wbe[b]) mem[bus.sram_addr][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
        end
        written[bus.sram_addr] <= 1'b1;
      end else begin
        bus.sram_rdata <= written[bus.sram_addr] ? mem[bus.sram_addr] : {BW{bus.sram_addr}};
      end
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every alloc pulse must match the oldest outstanding expected row.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && bus.ram_buff_alloc_vld === 1'b1) begin
      n_alloc++;
      check("alloc_expected", DW'(sb.size() != 0), 128'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("alloc_addr", DW'(bus.ram_buff_alloc_addr), DW'(e.addr));
        check("alloc_data", bus.ram_buff_alloc_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    exp_t e;
    if (bus.ram_read_vld === 1'b1 && bus.ram_read_rdy === 1'b1) begin
      e.addr = bus.ram_read_addr;
      e.data = rd_exp;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ram_read_vld  = 1'b0;
    bus.ram_read_addr = 8'h00;
    bus.wr_vld        = 1'b0;
    bus.wr_addr       = 8'h00;
    bus.wr_data       = {DW{1'b0}};
    bus.wr_strb       = {BW{1'b0}};
  endtask

  task automatic offer(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ram_read_vld  = 1'b1;
    bus.ram_read_addr = a;
    rd_exp            = d;
  endtask

  initial begin
    logic [7:0] a;
    int k;
    rst_n = 1'b0;
    rd_exp = {DW{1'b0}};
    idle();
    repeat (3) @(posedge clk);
    sample();
    check("rst_read_rdy", bus.ram_read_rdy, 1'b0);
    check("rst_wr_rdy", bus.wr_rdy, 1'b0);
    check("rst_sram_ce", bus.sram_ce, 1'b0);
    check("rst_alloc_vld", bus.ram_buff_alloc_vld, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sample();
    check("init_read_rdy", bus.ram_read_rdy, 1'b1);
    check("init_wr_rdy", bus.wr_rdy, 1'b1);
    advance();

    // Single read of row 0x05
    offer(8'h05, {BW{8'h05}});
    sample(); advance();
    bus.ram_read_vld = 1'b0;
    sample();
    check("rd1_sram_ce", bus.sram_ce, 1'b1);
    check("rd1_sram_we", bus.sram_we, 1'b0);
    check("rd1_sram_addr", bus.sram_addr, 8'h05);
    check("rd1_sram_wbe", bus.sram_wbe, 16'h0000);
    check("rd1_alloc_t1", bus.ram_buff_alloc_vld, 1'b0);
    advance(); sample();
    check("rd1_sram_ce_t2", bus.sram_ce, 1'b0);
    check("rd1_alloc_t2", bus.ram_buff_alloc_vld, 1'b0);
    advance(); sample();
    check("rd1_alloc_t3", bus.ram_buff_alloc_vld, 1'b1);
    check("rd1_alloc_addr", bus.ram_buff_alloc_addr, 8'h05);
    advance(); sample();
    check("rd1_alloc_t4", bus.ram_buff_alloc_vld, 1'b0);
    check("rd1_hold_addr", bus.ram_buff_alloc_addr, 8'h05);
    check("rd1_hold_data", bus.ram_buff_alloc_data, {BW{8'h05}});
    advance();

    // Write then read the same row
    bus.wr_vld = 1'b1; bus.wr_addr = 8'h10; bus.wr_data = {BW{8'hAA}}; bus.wr_strb = {BW{1'b1}};
    sample();
    check("raw_wr_rdy", bus.wr_rdy, 1'b1);
    check("raw_sram_we", bus.sram_we, 1'b1);
    check("raw_sram_addr", bus.sram_addr, 8'h10);
    check("raw_sram_wbe", bus.sram_wbe, 16'hFFFF);
    advance();
    bus.wr_vld = 1'b0;
    offer(8'h10, {BW{8'hAA}});
    sample(); advance();
    bus.ram_read_vld = 1'b0;
    repeat (4) begin sample(); advance(); end

    // Full queue with writes held high
    bus.wr_vld = 1'b1; bus.wr_addr = 8'h80; bus.wr_data = {BW{8'h55}};
    k = 0;
    for (int c = 0; c < 6; c++) begin
      a = 8'h20 + 8'(k);
      offer(a, {BW{a}});
      sample();
      if (c == 4) begin
        check("full_read_rdy", bus.ram_read_rdy, 1'b0);
        check("full_count", dut.count_r, 3'd4);
        check("full_wr_rdy", bus.wr_rdy, 1'b0);
        check("full_sram_we", bus.sram_we, 1'b0);
        check("full_sram_addr", bus.sram_addr, 8'h20);
      end
      if (c == 5) check("full_5th_rdy", bus.ram_read_rdy, 1'b1);
      if (bus.ram_read_rdy === 1'b1) k++;
      advance();
    end
    check("full_accepted", k, 5);
    idle();
    repeat (8) begin sample(); advance(); end

    // Starvation limit
    bus.wr_vld = 1'b1; bus.wr_addr = 8'h81; bus.wr_data = {BW{8'h33}}; bus.wr_strb = {BW{1'b1}};
    offer(8'h30, {BW{8'h30}});
    sample(); advance();
    bus.ram_read_vld = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      sample();
      check("stv_wr_gnt", bus.wr_rdy & bus.sram_we, 1'b1);
      advance();
    end
    sample();
    check("stv_wr_rdy", bus.wr_rdy, 1'b0);
    check("stv_rd_ce", bus.sram_ce, 1'b1);
    check("stv_rd_we", bus.sram_we, 1'b0);
    check("stv_rd_addr", bus.sram_addr, 8'h30);
    advance(); sample();
    check("stv_cnt_clear", dut.starve_cnt_r, 2'd0);
    check("stv_wr_resume", bus.wr_rdy & bus.sram_we, 1'b1);
    advance();
    idle();
    repeat (4) begin sample(); advance(); end

    // Back-to-back stream
    for (int c = 0; c < 9; c++) begin
      if (c < 4) offer(8'(c), {BW{8'(c)}});
      else bus.ram_read_vld = 1'b0;
      sample();
      if (c >= 3 && c <= 6) begin
        check("strm_alloc_vld", bus.ram_buff_alloc_vld, 1'b1);
        check("strm_alloc_addr", bus.ram_buff_alloc_addr, 8'(c - 3));
      end else begin
        check("strm_alloc_idle", bus.ram_buff_alloc_vld, 1'b0);
      end
      advance();
    end

    // Reset with two reads queued behind writes
    bus.wr_vld = 1'b1; bus.wr_addr = 8'h82; bus.wr_data = {BW{8'h77}}; bus.wr_strb = {BW{1'b1}};
    offer(8'h40, {BW{8'h40}});
    sample(); advance();
    offer(8'h41, {BW{8'h41}});
    sample(); advance();
    bus.ram_read_vld = 1'b0;
    sample();
    check("rst_pre_count", dut.count_r, 3'd2);
    saved_alloc = n_alloc;
    rst_n = 1'b0;
    idle();
    sb.delete();
    #1;
    check("rst_mid_count", dut.count_r, 3'd0);
    check("rst_mid_read_rdy", bus.ram_read_rdy, 1'b0);
    check("rst_mid_sram_ce", bus.sram_ce, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sample();
    check("rel_read_rdy_early", bus.ram_read_rdy, 1'b0);
    advance(); sample();
    check("rel_read_rdy", bus.ram_read_rdy, 1'b1);
    advance();
    repeat (5) begin sample(); advance(); end
    check("rst_no_alloc", n_alloc, saved_alloc);
    check("alloc_total", n_alloc, 12);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_rd_resp.md
RAM_RD_RESP -- requirements
Module: ram_rd_resp

Interface
REQ-001 The block SHALL have parameters ADDR_WIDTH, default 8, meaning the RAM row address width.
REQ-002 The block SHALL have parameters DATA_WIDTH, default 128, meaning the RAM row width in bits.
REQ-003 The block SHALL have parameters FIFO_DEPTH, default 4, meaning the number of read-request queue entries.
REQ-004 The block SHALL have parameters STARVE_MAX, default 3, meaning the number of consecutive write grants allowed while a read waits.
REQ-005 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  the single clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ram_read_vld  in  1  read request from the RAM buffer.
- ram_read_addr  in  ADDR_WIDTH  read row address.
- ram_read_rdy  out  1  request accepted when vld&rdy at a rising edge.
- wr_vld  in  1  write request from the AXI write side.
- wr_addr  in  ADDR_WIDTH  write row address.
- wr_data  in  DATA_WIDTH  write data.
- wr_strb  in  DATA_WIDTH/8  per-byte write enables.
- wr_rdy  out  1  write accepted when wr_vld&wr_rdy.
- sram_ce  out  1  SRAM macro chip enable.
- sram_we  out  1  1 = write, 0 = read.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_wdata  out  DATA_WIDTH  SRAM write data.
- sram_wbe  out  DATA_WIDTH/8  SRAM byte enables.
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid one cycle after a read with sram_ce=1.
- ram_buff_alloc_vld  out  1  returned-row valid, one-cycle pulse per read.
- ram_buff_alloc_addr  out  ADDR_WIDTH  address of the returned row.
- ram_buff_alloc_data  out  DATA_WIDTH  returned row data.

Function
REQ-006 The request FIFO SHALL be FIFO_DEPTH entries, in-order, and store the address only, with a count width of clog2(FIFO_DEPTH)+1.
REQ-007 The FIFO SHALL push on ram_read_vld&ram_read_rdy and pop on a read grant; push and pop in the same cycle SHALL leave the count unchanged.
REQ-008 ram_read_rdy SHALL equal init_done & (count < FIFO_DEPTH); there is no bypass, so an accepted request is issued no earlier than the next cycle.
REQ-009 init_done SHALL be a register that is 0 in reset and becomes 1 on the first rising edge after rst_n deasserts.
REQ-010 Arbitration, per cycle, with rd_pend = (count != 0) and force_rd = rd_pend & (starve_cnt == STARVE_MAX):
- wr_rdy SHALL equal init_done & ~force_rd.
- A write grant (wr_vld & wr_rdy) SHALL drive sram_ce=1, sram_we=1, with wr_addr, wr_data and wr_strb passed through.
- Otherwise, if init_done & rd_pend, a read grant SHALL drive sram_ce=1, sram_we=0, sram_addr=FIFO head, sram_wbe=0.
- Otherwise sram_ce SHALL be 0.
REQ-011 starve_cnt SHALL increment (saturating) on a write grant while rd_pend, and SHALL clear on a read grant or when the FIFO is empty.
REQ-012 The read pipeline SHALL register the read grant and its address into a stage-1 flag and stage-1 address; in the cycle after, it SHALL register sram_rdata, the stage-1 address and the stage-1 flag into the alloc outputs.
REQ-013 Read latency from request acceptance at edge T SHALL be: SRAM issue in cycle T+1, alloc_vld high in cycle T+3; back-to-back reads SHALL return one row per cycle.
REQ-014 ram_buff_alloc_vld SHALL be a single-cycle pulse; ram_buff_alloc_data and ram_buff_alloc_addr SHALL hold their value when alloc_vld is 0.
REQ-015 Rows SHALL be returned in acceptance order; a read accepted after a write to the same address SHALL return the new data, since the single port serialises the accesses.
REQ-016 There is no return back-pressure, so the consumer SHALL always accept alloc data.
REQ-017 Address arithmetic SHALL be none; addresses SHALL be passed through unmodified with no wrap handling.

Reset
REQ-018 rst_n low SHALL asynchronously clear FIFO pointers, count, starve_cnt, init_done, the stage-1 flag/address, ram_buff_alloc_vld/addr/data (all 0).
REQ-019 In reset, ram_read_rdy, wr_rdy and sram_ce SHALL be 0.
REQ-020 A reset asserted mid-operation SHALL discard queued and in-flight reads with no alloc pulse.

Verification
REQ-021 Single read: after reset, read addr 0x05 accepted at edge T, SRAM row 0x05 = D -> sram_ce=1/we=0/addr=0x05 in T+1, alloc_vld=1/addr=0x05/data=D in T+3 only.
REQ-022 Full FIFO: wr_vld held high and 5 reads offered on consecutive cycles -> first 4 accepted, ram_read_rdy=0 with count=4, 5th accepted after the first read grant.
REQ-023 Starvation: wr_vld held high continuously with 1 read queued -> 3 write grants, then wr_rdy=0 for one cycle with a read grant, then starve_cnt=0 and writes resume.
REQ-024 RAW ordering: write 0xAA..AA to addr 0x10 with full strb, read 0x10 the next cycle -> alloc_data=0xAA..AA.
REQ-025 Streaming plus reset: 4 back-to-back reads 0x00..0x03 -> alloc pulses on 4 consecutive cycles in order; then, with 2 reads queued, assert rst_n -> no alloc pulse, count=0, and ram_read_rdy=1 one cycle after release.
